opb_irq_ctrl: RTL

OPB-slave interrupt controller sitting between the application's `app_irq` sources and the system block's single active-low interrupt line. It synchronises 16 requests, latches edge- or level-type events into a pending register, masks and prioritises them, and drives a registered `irq_n` toward the PowerPC/host. Software services interrupts through a small OPB register map: read the vector, clear by write-1, re-enable.

---
 rtl/opb_irq_pkg.sv | 32 +++
 rtl/irq_sync_edge.sv | 30 +++
 rtl/opb_irq_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/opb_irq_pkg.sv
// Shared definitions for the OPB interrupt controller: register map, bus FSM
// states and the OPB big-endian to register bit-order conversion.
package opb_irq_pkg;

  localparam logic [31:0] OFF_STATUS   = 32'h00;
  localparam logic [31:0] OFF_PENDING  = 32'h04;
  localparam logic [31:0] OFF_ENABLE   = 32'h08;
  localparam logic [31:0] OFF_ACTIVE   = 32'h0C;
  localparam logic [31:0] OFF_VECTOR   = 32'h10;
  localparam logic [31:0] OFF_CONTROL  = 32'h14;
  localparam logic [31:0] OFF_SOFT_SET = 32'h18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } bus_state_e;

  // OPB numbers bit 0 as the MSB; register bit n lives on bus bit 31-n.
  function automatic logic [31:0] opb_to_reg(input logic [0:31] v);
    logic [31:0] r;
    for (int n = 0; n < 32; n++) r[n] = v[31-n];
    return r;
  endfunction

  function automatic logic [0:31] reg_to_opb(input logic [31:0] v);
    logic [0:31] r;
    for (int n = 0; n < 32; n++) r[31-n] = v[n];
    return r;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous request plus a rising-edge
// detector on the synchronised level.
module irq_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= async_in;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign rise  = sync_p1 & ~prev_p2;

endmodule

// File: rtl/opb_irq_ctrl.sv
// OPB slave interrupt controller: synchronises app_irq, latches edge/level
// events into PENDING, masks with ENABLE and drives a registered irq_n.
module opb_irq_ctrl
  import opb_irq_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR  = 32'h00010000,
  parameter logic [31:0] C_HIGHADDR  = 32'h0001FFFF,
  parameter int          C_NUM_IRQ   = 16,
  parameter logic [15:0] C_EDGE_MASK = 16'hFFFF
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst_n,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  input  logic [15:0] app_irq,
  output logic        irq_n
);

  localparam logic [15:0] IRQ_MASK = 16'((32'h1 << C_NUM_IRQ) - 32'h1);

  logic [15:0] level_s, rise_s;
  logic [15:0] pending, enable, active, status;
  logic        control;
  logic [15:0] pend_clr, soft_set, edge_next, level_next, pending_next;
  logic        vec_valid;
  logic [3:0]  vec_idx;

  bus_state_e  state;
  logic [31:0] addr_in, off_in, wdata_in, bemask_in, rd_data, rdata_q;
  logic [31:0] off_q, wdata_q, bemask_q, wr_bits;
  logic        rnw_q, in_window, acc_start, wr_en;
  logic        unused_bits;

  for (genvar gi = 0; gi < 16; gi++) begin : g_sync
    irq_sync_edge u_sync (
      .clk      (OPB_Clk),
      .rst_n    (OPB_Rst_n),
      .async_in (app_irq[gi]),
      .level    (level_s[gi]),
      .rise     (rise_s[gi])
    );
  end

  assign status = level_s & IRQ_MASK;
  assign active = pending & enable;

  // Bus decode and byte-enable expansion
  assign addr_in   = opb_to_reg(OPB_ABus);
  assign wdata_in  = opb_to_reg(OPB_DBus);
  assign off_in    = addr_in - C_BASEADDR;
  assign in_window = (addr_in >= C_BASEADDR) && (addr_in <= C_HIGHADDR);
  assign acc_start = (state == ST_IDLE) && OPB_select && in_window;

  always_comb begin
    bemask_in = '0;
    for (int i = 0; i < 4; i++) bemask_in[31-8*i -: 8] = {8{OPB_BE[i]}};
  end

  always_comb begin
    vec_valid = |active;
    vec_idx   = '0;
    for (int i = 15; i >= 0; i--) if (active[i]) vec_idx = 4'(i);
  end

  always_comb begin
    case (off_in)
      OFF_STATUS:  rd_data = {16'h0, status};
      OFF_PENDING: rd_data = {16'h0, pending};
      OFF_ENABLE:  rd_data = {16'h0, enable};
      OFF_ACTIVE:  rd_data = {16'h0, active};
      OFF_VECTOR:  rd_data = {vec_valid, 27'h0, vec_idx};
      OFF_CONTROL: rd_data = {31'h0, control};
      default:     rd_data = 32'h0;
    endcase
  end

  // Transfer attributes captured when the access is accepted
  always_ff @(posedge OPB_Clk) begin
    if (acc_start) begin
      off_q    <= off_in;
      wdata_q  <= wdata_in;
      bemask_q <= bemask_in;
      rnw_q    <= OPB_RNW;
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state      <= ST_IDLE;
      Sl_xferAck <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (acc_start) begin
            state      <= ST_ACK;
            Sl_xferAck <= 1'b1;
            rdata_q    <= OPB_RNW ? rd_data : 32'h0;
          end
        end
        ST_ACK: begin
          state      <= ST_HOLD;
          Sl_xferAck <= 1'b0;
          rdata_q    <= '0;
        end
        ST_HOLD: state <= ST_IDLE;
        default: begin
          state      <= ST_IDLE;
          Sl_xferAck <= 1'b0;
          rdata_q    <= '0;
        end
      endcase
    end
  end

  // Register writes commit on the edge that leaves ACK
  assign wr_en    = (state == ST_ACK) && !rnw_q;
  assign wr_bits  = wdata_q & bemask_q;
  assign pend_clr = (wr_en && off_q == OFF_PENDING)  ? wr_bits[15:0] : 16'h0;
  assign soft_set = (wr_en && off_q == OFF_SOFT_SET) ? wr_bits[15:0] : 16'h0;

  // A hardware edge in the same cycle as a W1C keeps the bit pending.
  always_comb begin
    edge_next    = (pending & ~pend_clr) | rise_s | soft_set;
    level_next   = level_s | soft_set;
    pending_next = ((C_EDGE_MASK & edge_next) | (~C_EDGE_MASK & level_next)) & IRQ_MASK;
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      pending <= '0;
      enable  <= '0;
      control <= 1'b0;
      irq_n   <= 1'b1;
    end else begin
      pending <= pending_next;
      if (wr_en && off_q == OFF_ENABLE)
        enable <= ((enable & ~bemask_q[15:0]) | wr_bits[15:0]) & IRQ_MASK;
      if (wr_en && off_q == OFF_CONTROL)
        control <= (control & ~bemask_q[0]) | wr_bits[0];
      irq_n <= ~(control & |active);
    end
  end

  assign Sl_DBus    = reg_to_opb(rdata_q);
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign unused_bits = ^{OPB_seqAddr, wr_bits[31:16]};

endmodule
